// File: rtl/spi_dev_fread_pkg.sv
// spi_dev_fread_pkg: shared constants, descriptor layout and tag-width helper for the fread engine
package spi_dev_fread_pkg;
    localparam logic [7:0] CMD_GET_BYTE = 8'hf8;
    localparam logic [7:0] CMD_PUT_BYTE = 8'hf9;
    localparam int DESC_BYTES = 11;
    localparam logic [7:0] NO_DESC_BYTE = 8'hff;
    // Sized for the largest legal QDEPTH / LEN_W so the layout is fixed.
    typedef struct packed {
        logic [3:0]  tag;
        logic [31:0] file_id;
        logic [31:0] offset;
        logic [15:0] len;
    } desc_t;
    typedef enum logic [1:0] {CMD_IDLE, CMD_GET, CMD_PUT} cmd_e;
    function automatic int tag_w(input int q);
        return (q <= 2) ? 1 : $clog2(q);
    endfunction
endpackage

// File: rtl/fread_desc_fifo.sv
// fread_desc_fifo: show-ahead descriptor FIFO of DEPTH entries.
// Ports: clk/rst, push_i + wdata_i write, pop_i advances head, rdata_o is the head, empty_o.
module fread_desc_fifo import spi_dev_fread_pkg::*; #(
    parameter int DEPTH = 4,
    localparam int AW = tag_w(DEPTH)
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push_i,
    input  logic  pop_i,
    input  desc_t wdata_i,
    output desc_t rdata_o,
    output logic  empty_o
);
    desc_t mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0] cnt_q;
    logic do_pop;
    assign empty_o = (cnt_q == '0);
    assign do_pop = pop_i && !empty_o;
    assign rdata_o = mem_q[rp_q];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/spi_dev_fread_mq.sv
// spi_dev_fread_mq: tagged multi-outstanding file-read engine behind the SPI protocol wrapper.
// Ports: pw_* wrapper byte interface (GET/PUT commands), req_* fabric request handshake,
// resp_* tagged response byte stream, pending = allocated slot mask.
module spi_dev_fread_mq import spi_dev_fread_pkg::*; #(
    parameter int QDEPTH = 4,
    parameter int LEN_W = 16,
    localparam int TW = tag_w(QDEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       pw_wdata,
    input  logic             pw_wcmd,
    input  logic             pw_wstb,
    input  logic             pw_end,
    output logic             pw_req,
    input  logic             pw_gnt,
    output logic [7:0]       pw_rdata,
    output logic             pw_rstb,
    output logic             pw_irq,
    input  logic [31:0]      req_file_id,
    input  logic [31:0]      req_offset,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_valid,
    output logic             req_ready,
    output logic [TW-1:0]    req_tag,
    output logic [7:0]       resp_data,
    output logic [TW-1:0]    resp_tag,
    output logic             resp_valid,
    output logic             resp_last,
    output logic             resp_err,
    output logic [QDEPTH-1:0] pending
);
    cmd_e cmd_q;
    logic [QDEPTH-1:0] busy_q, busy_d;
    logic [LEN_W-1:0] rem_q [QDEPTH];
    logic [LEN_W-1:0] rem_d [QDEPTH];
    logic [LEN_W-1:0] cur_rem;
    logic [3:0] idx_q;
    logic [TW-1:0] ptag_q, free_tag;
    logic first_q, ok_q, exh_q, ovr_q;
    logic any_free, push, pop, empty, send_desc, send_ff;
    logic put_byte, tag_bad, data_ok, data_ovr, zero_free;
    desc_t head, new_desc;
    logic [87:0] desc_v;
    logic [7:0] get_byte;
    always_comb begin
        free_tag = '0;
        any_free = 1'b0;
        for (int i = QDEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_tag = TW'(i);
                any_free = 1'b1;
            end
        end
    end
    assign req_ready = any_free;
    assign req_tag = free_tag;
    assign pending = busy_q;
    assign pw_irq = !empty;
    assign pw_req = (cmd_q == CMD_GET);
    assign push = req_valid && any_free;
    assign new_desc = {4'(free_tag), req_file_id, req_offset, 16'(req_len)};
    fread_desc_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push_i(push), .pop_i(pop),
        .wdata_i(new_desc), .rdata_o(head), .empty_o(empty)
    );
    // Byte 0 is {pad, tag}; remaining fields follow big-endian.
    assign desc_v = {4'b0000, head};
    assign get_byte = desc_v[7'd80 - {idx_q, 3'b000} +: 8];
    // idx_q parks at 4'hf after the no-descriptor byte so nothing more is sent.
    assign send_desc = pw_req && pw_gnt && !empty && (idx_q < 4'(DESC_BYTES));
    assign send_ff = pw_req && pw_gnt && empty && (idx_q == 4'd0);
    assign pop = pw_end && pw_req && (idx_q == 4'(DESC_BYTES));
    assign put_byte = pw_wstb && !pw_wcmd && (cmd_q == CMD_PUT);
    assign tag_bad = (pw_wdata >= 8'(QDEPTH)) || !busy_q[pw_wdata[TW-1:0]];
    assign cur_rem = rem_q[ptag_q];
    // exh_q guards against a slot freed earlier in this PUT being reallocated meanwhile.
    assign data_ok = put_byte && !first_q && ok_q && !exh_q && (cur_rem != '0);
    assign data_ovr = put_byte && !first_q && ok_q && !data_ok;
    assign zero_free = pw_end && (cmd_q == CMD_PUT) && !first_q && ok_q && !exh_q && (cur_rem == '0);
    always_comb begin
        busy_d = busy_q;
        rem_d = rem_q;
        if (data_ok) begin
            rem_d[ptag_q] = cur_rem - LEN_W'(1);
            if (cur_rem == LEN_W'(1)) busy_d[ptag_q] = 1'b0;
        end
        if (zero_free) busy_d[ptag_q] = 1'b0;
        if (push) begin
            busy_d[free_tag] = 1'b1;
            rem_d[free_tag] = req_len;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q <= CMD_IDLE;
            busy_q <= '0;
            rem_q <= '{default: '0};
            idx_q <= '0;
            ptag_q <= '0;
            first_q <= 1'b0;
            ok_q <= 1'b0;
            exh_q <= 1'b0;
            ovr_q <= 1'b0;
            pw_rdata <= 8'h00;
            pw_rstb <= 1'b0;
            resp_data <= 8'h00;
            resp_tag <= '0;
            resp_valid <= 1'b0;
            resp_last <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            busy_q <= busy_d;
            rem_q <= rem_d;
            pw_rstb <= send_desc || send_ff;
            if (send_desc) begin
                pw_rdata <= get_byte;
                idx_q <= idx_q + 4'd1;
            end else if (send_ff) begin
                pw_rdata <= NO_DESC_BYTE;
                idx_q <= 4'hf;
            end
            resp_valid <= data_ok;
            resp_last <= data_ok && (cur_rem == LEN_W'(1));
            resp_err <= (put_byte && first_q && tag_bad) || (data_ovr && !ovr_q);
            if (data_ok) begin
                resp_data <= pw_wdata;
                resp_tag <= ptag_q;
            end
            if (data_ok && cur_rem == LEN_W'(1)) exh_q <= 1'b1;
            if (data_ovr) ovr_q <= 1'b1;
            if (put_byte && first_q) begin
                first_q <= 1'b0;
                ok_q <= !tag_bad;
                ptag_q <= pw_wdata[TW-1:0];
            end
            if (pw_end) begin
                cmd_q <= CMD_IDLE;
            end else if (pw_wstb && pw_wcmd) begin
                cmd_q <= (pw_wdata == CMD_GET_BYTE) ? CMD_GET : (pw_wdata == CMD_PUT_BYTE) ? CMD_PUT : CMD_IDLE;
                idx_q <= '0;
                first_q <= 1'b1;
                ok_q <= 1'b0;
                exh_q <= 1'b0;
                ovr_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_dev_fread_mq.sv
// tb_spi_dev_fread_mq: scoreboard bench for the fread engine (GET/PUT, tags, splits, aborts, reset)
module tb_spi_dev_fread_mq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] pw_wdata = '0;
    logic pw_wcmd = 0, pw_wstb = 0, pw_end = 0, pw_gnt = 0;
    logic pw_req, pw_rstb, pw_irq;
    logic [7:0] pw_rdata;
    logic [31:0] req_file_id = '0, req_offset = '0;
    logic [15:0] req_len = '0;
    logic req_valid = 0, req_ready;
    logic [1:0] req_tag, resp_tag;
    logic [7:0] resp_data;
    logic resp_valid, resp_last, resp_err;
    logic [3:0] pending;
    int errors = 0, checks = 0;
    logic [7:0] exp_rd[$], obs_rd[$];
    logic [10:0] exp_resp[$], obs_resp[$];
    logic [87:0] mdesc[$];
    logic mbusy[4];
    int mrem[4];
    int exp_err, obs_err;

    always #5 clk = ~clk;

    spi_dev_fread_mq dut (
        .clk(clk), .rst(rst), .pw_wdata(pw_wdata), .pw_wcmd(pw_wcmd), .pw_wstb(pw_wstb),
        .pw_end(pw_end), .pw_req(pw_req), .pw_gnt(pw_gnt), .pw_rdata(pw_rdata), .pw_rstb(pw_rstb),
        .pw_irq(pw_irq), .req_file_id(req_file_id), .req_offset(req_offset), .req_len(req_len),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_valid(resp_valid), .resp_last(resp_last), .resp_err(resp_err),
        .pending(pending)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (pw_rstb) obs_rd.push_back(pw_rdata);
        if (resp_valid) obs_resp.push_back({resp_tag, resp_last, resp_data});
        if (resp_err) obs_err++;
    endtask

    task automatic wr_byte(input logic c, input logic [7:0] d);
        pw_wdata = d;
        pw_wcmd = c;
        pw_wstb = 1;
        step();
        pw_wstb = 0;
        pw_wcmd = 0;
    endtask

    task automatic end_txn();
        pw_end = 1;
        step();
        pw_end = 0;
    endtask

    task automatic clear_sb();
        exp_rd.delete(); obs_rd.delete(); exp_resp.delete(); obs_resp.delete();
        exp_err = 0; obs_err = 0;
    endtask

    task automatic model_reset();
        mdesc.delete();
        for (int i = 0; i < 4; i++) begin mbusy[i] = 0; mrem[i] = 0; end
    endtask

    task automatic submit(input logic [31:0] f, input logic [31:0] o, input logic [15:0] l);
        int t = -1;
        for (int i = 3; i >= 0; i--) if (!mbusy[i]) t = i;
        req_file_id = f; req_offset = o; req_len = l; req_valid = 1;
        step();
        req_valid = 0;
        if (t >= 0) begin
            mbusy[t] = 1; mrem[t] = l;
            mdesc.push_back({4'b0, 4'(t), f, o, l});
        end
    endtask

    // GET with the grant held for 'limit' cycles; fewer than 11 aborts the fetch.
    task automatic do_get(input int limit);
        int n = (limit < 11) ? limit : 11;
        if (mdesc.size() == 0) exp_rd.push_back(8'hff);
        else begin
            for (int k = 0; k < n; k++) exp_rd.push_back(8'(mdesc[0] >> (8 * (10 - k))));
            if (limit >= 11) void'(mdesc.pop_front());
        end
        wr_byte(1, 8'hf8);
        pw_gnt = 1;
        repeat (limit) step();
        pw_gnt = 0;
        step();
        end_txn();
        step();
    endtask

    // PUT with n data bytes base, base+11h, base+22h, ...
    task automatic do_put(input logic [7:0] tag, input int n, input logic [7:0] base);
        logic ok, ovr, last;
        logic [7:0] d;
        ok = (tag < 4) && mbusy[tag[1:0]];
        ovr = 0;
        if (!ok) exp_err++;
        wr_byte(1, 8'hf9);
        wr_byte(0, tag);
        for (int i = 0; i < n; i++) begin
            d = base + 8'(i * 17);
            wr_byte(0, d);
            if (ok) begin
                if (mrem[tag[1:0]] > 0) begin
                    mrem[tag[1:0]]--;
                    last = (mrem[tag[1:0]] == 0);
                    exp_resp.push_back({tag[1:0], last, d});
                    if (last) mbusy[tag[1:0]] = 0;
                end else if (!ovr) begin
                    ovr = 1;
                    exp_err++;
                end
            end
        end
        end_txn();
        if (ok && mbusy[tag[1:0]] && mrem[tag[1:0]] == 0) mbusy[tag[1:0]] = 0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) step();
        rst = 0;
        step();
        checks++;
        if ({pw_req, pw_rstb, pw_rdata, pw_irq, req_ready, req_tag, resp_valid, resp_last, resp_err, pending}
            !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_vals: got req=%b rstb=%b rdata=%h irq=%b rdy=%b tag=%0d rv=%b rl=%b re=%b pend=%b, want all idle, rdy=1",
                     pw_req, pw_rstb, pw_rdata, pw_irq, req_ready, req_tag, resp_valid, resp_last, resp_err, pending);
        end
    endtask

    task automatic test_get_empty();
        logic [7:0] e, o;
        clear_sb();
        do_get(14);
        checks++;
        if (obs_rd.size() != exp_rd.size()) begin errors++; $display("FAIL empty_get_count: got %0d want %0d", obs_rd.size(), exp_rd.size()); end
        while (exp_rd.size() && obs_rd.size()) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL empty_get_byte: got %h want %h", o, e); end
        end
        checks++;
        if ({pw_irq, pending} !== 5'b0) begin errors++; $display("FAIL empty_get_state: got irq=%b pend=%b want 0/0000", pw_irq, pending); end
    endtask

    task automatic test_get_desc();
        logic [7:0] e, o;
        logic [10:0] er, orr;
        clear_sb();
        submit(32'h01020304, 32'h00000100, 16'd3);
        checks++;
        if ({pw_irq, pending} !== 5'b1_0001) begin errors++; $display("FAIL desc_queued: got irq=%b pend=%b want 1/0001", pw_irq, pending); end
        do_get(14);
        checks++;
        if (obs_rd.size() != 11) begin errors++; $display("FAIL desc_count: got %0d want 11", obs_rd.size()); end
        while (exp_rd.size() && obs_rd.size()) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL desc_byte: got %h want %h", o, e); end
        end
        checks++;
        if ({pw_irq, pending} !== 5'b0_0001) begin errors++; $display("FAIL desc_popped: got irq=%b pend=%b want 0/0001", pw_irq, pending); end
        do_put(8'd0, 3, 8'h10);
        checks++;
        if (obs_resp.size() != exp_resp.size()) begin errors++; $display("FAIL desc_resp_count: got %0d want %0d", obs_resp.size(), exp_resp.size()); end
        while (exp_resp.size() && obs_resp.size()) begin
            er = exp_resp.pop_front(); orr = obs_resp.pop_front(); checks++;
            if (orr !== er) begin errors++; $display("FAIL desc_resp: got %h want %h", orr, er); end
        end
    endtask

    task automatic test_out_of_order();
        logic [10:0] er, orr;
        clear_sb();
        checks++;
        if (req_tag !== 2'd0) begin errors++; $display("FAIL ooo_tag0: got %0d want 0", req_tag); end
        submit(32'hA, 32'h0, 16'd2);
        checks++;
        if (req_tag !== 2'd1) begin errors++; $display("FAIL ooo_tag1: got %0d want 1", req_tag); end
        submit(32'hB, 32'h0, 16'd2);
        do_put(8'd1, 2, 8'hAA);
        checks++;
        if (pending !== 4'b0001) begin errors++; $display("FAIL ooo_pending: got %b want 0001", pending); end
        do_put(8'd0, 2, 8'h11);
        checks++;
        if (obs_resp.size() != 4 || exp_resp.size() != 4) begin errors++; $display("FAIL ooo_resp_count: got %0d want 4", obs_resp.size()); end
        while (exp_resp.size() && obs_resp.size()) begin
            er = exp_resp.pop_front(); orr = obs_resp.pop_front(); checks++;
            if (orr !== er) begin errors++; $display("FAIL ooo_resp: got %h want %h", orr, er); end
        end
        checks++;
        if ({obs_err, pending} !== {32'd0, 4'b0}) begin errors++; $display("FAIL ooo_end: got err=%0d pend=%b want 0/0000", obs_err, pending); end
    endtask

    task automatic test_split();
        logic [10:0] er, orr;
        clear_sb();
        submit(32'hC, 32'h40, 16'd4);
        do_put(8'd0, 2, 8'h20);
        checks++;
        if (pending !== 4'b0001) begin errors++; $display("FAIL split_mid_pending: got %b want 0001", pending); end
        do_put(8'd0, 3, 8'h30);
        checks++;
        if (obs_resp.size() != 4) begin errors++; $display("FAIL split_resp_count: got %0d want 4", obs_resp.size()); end
        while (exp_resp.size() && obs_resp.size()) begin
            er = exp_resp.pop_front(); orr = obs_resp.pop_front(); checks++;
            if (orr !== er) begin errors++; $display("FAIL split_resp: got %h want %h", orr, er); end
        end
        checks++;
        if (obs_err != 1 || exp_err != 1) begin errors++; $display("FAIL split_err: got %0d pulses want 1", obs_err); end
        checks++;
        if (pending !== 4'b0) begin errors++; $display("FAIL split_pending: got %b want 0000", pending); end
    endtask

    task automatic test_abort();
        logic [7:0] e, o;
        logic [7:0] first5[$];
        int guard = 0;
        clear_sb();
        do_get(5);
        checks++;
        if (obs_rd.size() != 5 || pw_irq !== 1'b1) begin errors++; $display("FAIL abort_partial: got %0d bytes irq=%b want 5/1", obs_rd.size(), pw_irq); end
        first5 = obs_rd;
        do_get(14);
        checks++;
        if (obs_rd.size() != 16) begin errors++; $display("FAIL abort_resend_count: got %0d want 16", obs_rd.size()); end
        for (int i = 0; i < 5 && i + 5 < obs_rd.size(); i++) begin
            checks++;
            if (obs_rd[i + 5] !== first5[i]) begin errors++; $display("FAIL abort_resend_same: byte %0d got %h want %h", i, obs_rd[i + 5], first5[i]); end
        end
        while (mdesc.size() && guard < 8) begin do_get(14); guard++; end
        while (exp_rd.size() && obs_rd.size()) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL abort_byte: got %h want %h", o, e); end
        end
        checks++;
        if (exp_rd.size() != obs_rd.size() || pw_irq !== 1'b0) begin errors++; $display("FAIL abort_drain: left exp=%0d obs=%0d irq=%b", exp_rd.size(), obs_rd.size(), pw_irq); end
    endtask

    task automatic test_zero_len();
        logic [7:0] e, o;
        clear_sb();
        submit(32'hD, 32'h0, 16'd0);
        do_get(14);
        while (exp_rd.size() && obs_rd.size()) begin
            e = exp_rd.pop_front(); o = obs_rd.pop_front(); checks++;
            if (o !== e) begin errors++; $display("FAIL zero_desc: got %h want %h", o, e); end
        end
        checks++;
        if (pending !== 4'b0001) begin errors++; $display("FAIL zero_pending: got %b want 0001", pending); end
        do_put(8'd0, 2, 8'h50);
        checks++;
        if (obs_resp.size() != 0 || obs_err != 1 || exp_err != 1) begin errors++; $display("FAIL zero_put: got resp=%0d err=%0d want 0/1", obs_resp.size(), obs_err); end
        checks++;
        if (pending !== 4'b0) begin errors++; $display("FAIL zero_freed: got %b want 0000", pending); end
    endtask

    task automatic test_full_and_rst();
        clear_sb();
        for (int i = 0; i < 4; i++) submit(32'h100 + i, 32'h0, 16'd1);
        checks++;
        if ({req_ready, pending} !== 5'b0_1111) begin errors++; $display("FAIL full: got rdy=%b pend=%b want 0/1111", req_ready, pending); end
        do_put(8'd7, 2, 8'h60);
        checks++;
        if (obs_resp.size() != 0 || obs_err != 1 || exp_err != 1) begin errors++; $display("FAIL bad_tag: got resp=%0d err=%0d want 0/1", obs_resp.size(), obs_err); end
        clear_sb();
        wr_byte(1, 8'hf9);
        wr_byte(0, 8'd0);
        rst = 1;
        #1;
        checks++;
        if ({pw_req, pw_rstb, pw_irq, req_ready, req_tag, resp_valid, resp_last, resp_err, pending}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL rst_async: got req=%b rstb=%b irq=%b rdy=%b tag=%0d pend=%b want idle", pw_req, pw_rstb, pw_irq, req_ready, req_tag, pending);
        end
        step();
        rst = 0;
        model_reset();
        step();
        checks++;
        if ({pw_req, pw_rstb, pw_rdata, pw_irq, req_ready, req_tag, resp_valid, resp_last, resp_err, pending}
            !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL rst_mid_put: got req=%b rstb=%b rdata=%h irq=%b rdy=%b tag=%0d pend=%b want reset values",
                     pw_req, pw_rstb, pw_rdata, pw_irq, req_ready, req_tag, pending);
        end
        submit(32'h200, 32'h0, 16'd1);
        wr_byte(0, 8'd0);
        wr_byte(0, 8'h77);
        step();
        checks++;
        if (obs_resp.size() != 0 || obs_err != 0 || pending !== 4'b0001) begin
            errors++;
            $display("FAIL rst_ignore: got resp=%0d err=%0d pend=%b want 0/0/0001", obs_resp.size(), obs_err, pending);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_get_empty();
        test_get_desc();
        test_out_of_order();
        test_split();
        test_abort();
        test_zero_len();
        test_full_and_rst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
